// File: rtl/a51_lfsr_reg.sv
// ============================================================================
// a51_lfsr_reg : A5/1-style LFSR with serial key/frame load and gated advance.
// Optional parallel load when A51_LFSR_PARLOAD_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module a51_lfsr_reg #(
    parameter int unsigned      WIDTH    = 23,
    parameter logic [WIDTH-1:0] TAPS     = 23'h700080,
    parameter int unsigned      CLK_BIT  = 10,
    parameter int unsigned      LOAD_LEN = 86
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             shift_bit,
    input  logic             trigger,
`ifdef A51_LFSR_PARLOAD_EN
    input  logic             par_load,
    input  logic [WIDTH-1:0] par_data,
`endif
    output logic             out_reg,
    output logic             clk_maj,
    output logic             busy,
    output logic             ready,
    output logic             lock_err,
    output logic [WIDTH-1:0] state_q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [15:0] C_LAST = 16'(LOAD_LEN - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [15:0]      r_cnt;
    logic             r_lock_err;
    logic             w_fb;
    logic             w_par_load;
    logic [WIDTH-1:0] w_par_data;

`ifdef A51_LFSR_PARLOAD_EN
    assign w_par_load = par_load;
    assign w_par_data = par_data;
`else
    assign w_par_load = 1'b0;
    assign w_par_data = '0;
`endif

    assign w_fb = ^(r_lfsr & TAPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_lfsr     <= '0;
            r_cnt      <= '0;
            r_lock_err <= 1'b0;
        end else begin
            // Flags the cycle after an all-zero register is seen while running.
            r_lock_err <= (r_state == ST_RUN) && (r_lfsr == '0);

            if (w_par_load) begin
                r_lfsr  <= w_par_data;
                r_cnt   <= '0;
                r_state <= ST_RUN;
            end else if (start) begin
                r_lfsr  <= '0;
                r_cnt   <= '0;
                r_state <= ST_LOAD;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_lfsr <= r_lfsr;
                    end
                    ST_LOAD: begin
                        r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb ^ shift_bit};
                        r_cnt  <= r_cnt + 16'd1;
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (trigger) begin
                            r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_reg  = r_lfsr[WIDTH-1];
    assign clk_maj  = r_lfsr[CLK_BIT];
    assign state_q  = r_lfsr;
    assign busy     = (r_state == ST_LOAD);
    assign ready    = (r_state == ST_RUN);
    assign lock_err = r_lock_err;

endmodule

`default_nettype wire

// File: tb/tb_a51_lfsr_reg.sv
// ============================================================================
// tb_a51_lfsr_reg : directed, table-driven bench for a51_lfsr_reg.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_a51_lfsr_reg;

    localparam logic [22:0] C_TAPS = 23'h700080;

    logic        clk = 1'b0;
    logic        reset, start, shift_bit, trigger;
    logic        out_reg, clk_maj, busy, ready, lock_err;
    logic [22:0] state_q;
`ifdef A51_LFSR_PARLOAD_EN
    logic        par_load;
    logic [22:0] par_data;
`endif

    // Second instance with a one-bit load for the all-zero lock case
    logic        start1, shift_bit1, trigger1;
    logic        out_reg1, clk_maj1, busy1, ready1, lock_err1;
    logic [22:0] state_q1;
`ifdef A51_LFSR_PARLOAD_EN
    logic        par_load1;
    logic [22:0] par_data1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    a51_lfsr_reg dut (
        .clk(clk), .reset(reset), .start(start), .shift_bit(shift_bit), .trigger(trigger),
`ifdef A51_LFSR_PARLOAD_EN
        .par_load(par_load), .par_data(par_data),
`endif
        .out_reg(out_reg), .clk_maj(clk_maj), .busy(busy), .ready(ready),
        .lock_err(lock_err), .state_q(state_q)
    );

    a51_lfsr_reg #(.LOAD_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .shift_bit(shift_bit1), .trigger(trigger1),
`ifdef A51_LFSR_PARLOAD_EN
        .par_load(par_load1), .par_data(par_data1),
`endif
        .out_reg(out_reg1), .clk_maj(clk_maj1), .busy(busy1), .ready(ready1),
        .lock_err(lock_err1), .state_q(state_q1)
    );

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic        sb;
        logic        trig;
        logic [22:0] q;
        logic        busy;
        logic        ready;
        logic        cmaj;
    } vec_t;

    vec_t        tbl[15];
    logic [22:0] m;
    logic        fb, want;
    int          busy_cnt;
    logic [22:0] target;

    initial begin
        // start, shift_bit, trigger -> state_q, busy, ready, clk_maj (starting from RUN, reg=1)
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 23'h000002, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 23'h000002, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 23'h000004, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 23'h000008, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 23'h000010, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 23'h000020, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 23'h000040, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 23'h000080, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 23'h000101, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 23'h000202, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 23'h000404, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 23'h000404, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 23'h000000, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 23'h000001, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 23'h000002, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; shift_bit = 1'b0; trigger = 1'b0;
        start1 = 1'b0; shift_bit1 = 1'b0; trigger1 = 1'b0;
`ifdef A51_LFSR_PARLOAD_EN
        par_load = 1'b0; par_data = '0; par_load1 = 1'b0; par_data1 = '0;
`endif
        step(); step();
        reset = 1'b0;
        repeat (5) step();
        check("rst_state_q", state_q, 23'h0);
        check("rst_out_reg", out_reg, 1'b0);
        check("rst_clk_maj", clk_maj, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_lock_err", lock_err, 1'b0);

        // Full default load of 86 ones against the software model
        start = 1'b1; step();
        start = 1'b0; shift_bit = 1'b1;
        m = '0; busy_cnt = 0;
        for (int s = 0; s < 86; s++) begin
            if (busy) busy_cnt++;
            fb = ^(m & C_TAPS);
            m  = {m[21:0], fb ^ 1'b1};
            step();
        end
        check("load1_busy_cycles", 23'(busy_cnt), 23'd86);
        check("load1_ready", ready, 1'b1);
        check("load1_busy_low", busy, 1'b0);
        check("load1_state_q", state_q, m);
        check("load1_out_reg", out_reg, m[22]);
        check("load1_clk_maj", clk_maj, m[10]);

        // Restart after 40 load cycles, then steer the load to reg=1
        start = 1'b1; step();
        start = 1'b0; shift_bit = 1'b1; m = '0;
        for (int s = 0; s < 40; s++) begin
            fb = ^(m & C_TAPS);
            m  = {m[21:0], fb ^ 1'b1};
            step();
        end
        check("mid_load_state_q", state_q, m);
        check("mid_load_busy", busy, 1'b1);
        start = 1'b1; step();
        check("restart_state_q", state_q, 23'h0);
        check("restart_busy", busy, 1'b1);
        start = 1'b0; m = '0; busy_cnt = 0; target = 23'h000001;
        for (int s = 0; s < 86; s++) begin
            if (busy) busy_cnt++;
            fb   = ^(m & C_TAPS);
            want = (s >= 63) ? target[85-s] : s[0];
            shift_bit = fb ^ want;
            m = {m[21:0], want};
            step();
        end
        check("restart_busy_cycles", 23'(busy_cnt), 23'd86);
        check("restart_ready", ready, 1'b1);
        check("restart_state_q", state_q, 23'h000001);

        for (int i = 0; i < 15; i++) begin
            start = tbl[i].start; shift_bit = tbl[i].sb; trigger = tbl[i].trig;
            step();
            check($sformatf("vec%0d_state_q", i), state_q, tbl[i].q);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("vec%0d_ready", i), ready, tbl[i].ready);
            check($sformatf("vec%0d_clk_maj", i), clk_maj, tbl[i].cmaj);
            check($sformatf("vec%0d_lock_err", i), lock_err, 1'b0);
        end

        // Reset beats start and trigger mid-load; IDLE then holds
        reset = 1'b1; start = 1'b1; trigger = 1'b1; shift_bit = 1'b1;
        step();
        check("rst_mid_state_q", state_q, 23'h0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", ready, 1'b0);
        reset = 1'b0; start = 1'b0;
        step();
        check("idle_hold_state_q", state_q, 23'h0);
        check("idle_hold_busy", busy, 1'b0);
        trigger = 1'b0; shift_bit = 1'b0;

        // LOAD_LEN=1 with a zero bit lands in RUN all-zero -> lock_err
        start1 = 1'b1; step();
        check("l1_busy", busy1, 1'b1);
        start1 = 1'b0; shift_bit1 = 1'b0; step();
        check("l1_ready", ready1, 1'b1);
        check("l1_state_q", state_q1, 23'h0);
        check("l1_lock_early", lock_err1, 1'b0);
        step();
        check("l1_lock_set", lock_err1, 1'b1);
        start1 = 1'b1; step();
        start1 = 1'b0; shift_bit1 = 1'b1; step();
        check("l1_reload_state_q", state_q1, 23'h000001);
        check("l1_lock_clear", lock_err1, 1'b0);
        shift_bit1 = 1'b0;

`ifdef A51_LFSR_PARLOAD_EN
        par_load = 1'b1; par_data = 23'h7FFFFF; start = 1'b1;
        step();
        check("par_ready", ready, 1'b1);
        check("par_busy", busy, 1'b0);
        check("par_state_q", state_q, 23'h7FFFFF);
        check("par_out_reg", out_reg, 1'b1);
        par_load = 1'b0; start = 1'b0; trigger = 1'b1;
        step();
        check("par_trig_state_q", state_q, 23'h7FFFFE);
        trigger = 1'b0; reset = 1'b1; par_load = 1'b1;
        step();
        check("par_rst_state_q", state_q, 23'h0);
        check("par_rst_ready", ready, 1'b0);
        reset = 1'b0; par_load = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/a51_lfsr_reg.md
A51_LFSR_REG -- requirements
Module: a51_lfsr_reg

Interface
REQ-001 Parameter WIDTH, default 23: LFSR length in bits; legal range 8..64.
REQ-002 Parameter TAPS, default 23'h700080: feedback tap mask, WIDTH bits wide; bit i set means reg[i] feeds parity (default taps are bits 22, 21, 20, 7).
REQ-003 Parameter CLK_BIT, default 10: index of the clocking (majority) bit; legal range 0..WIDTH-1.
REQ-004 Parameter LOAD_LEN, default 86: number of serial key/frame bits absorbed per load; legal range 1..65535.
REQ-005 clk  input  1  rising-edge clock; sole clock of the block.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin a serial load sequence.
REQ-008 shift_bit  input  1  serial key/frame bit; sampled only in LOAD.
REQ-009 trigger  input  1  advance enable; effective only in RUN.
REQ-010 out_reg  output  1  reg[WIDTH-1], the keystream contribution.
REQ-011 clk_maj  output  1  reg[CLK_BIT], the majority-vote input.
REQ-012 busy  output  1  high while in LOAD.
REQ-013 ready  output  1  high while in RUN.
REQ-014 lock_err  output  1  registered; high when in RUN and reg is all-zero.
REQ-015 state_q  output  WIDTH  current register contents, for debug and key readback.

Function
REQ-016 FSM states SHALL be IDLE, LOAD and RUN; the FSM state and reg SHALL update only on the rising edge of clk.
REQ-017 fb SHALL equal the XOR-reduce of (reg & TAPS).
REQ-018 Shift SHALL be toward the MSB: next = {reg[WIDTH-2:0], in_bit}, and reg[WIDTH-1] SHALL be discarded.
REQ-019 IDLE: start=1 -> reg<=0, cnt<=0, enter LOAD next cycle; otherwise reg holds.
REQ-020 LOAD: each cycle in_bit=fb^shift_bit and cnt<=cnt+1; when cnt==LOAD_LEN-1 that cycle's shift completes the load and the FSM enters RUN.
REQ-021 LOAD: exactly LOAD_LEN shifts occur; trigger SHALL be ignored.
REQ-022 RUN: trigger=1 -> shift with in_bit=fb (shift_bit ignored); trigger=0 -> reg holds.
REQ-023 start=1 in LOAD or RUN SHALL restart the load (reg<=0, cnt<=0, LOAD) and take precedence over trigger and over load completion in the same cycle.
REQ-024 cnt SHALL be 16 bits wide and SHALL never wrap, because LOAD exits at LOAD_LEN-1.
REQ-025 lock_err SHALL be set the cycle after RUN is observed with reg==0, and cleared the cycle after that condition is false.
REQ-026 out_reg, clk_maj and state_q SHALL be combinational from reg; busy and ready SHALL be decoded from the FSM state.

Reset
REQ-027 reset=1 at a clock edge SHALL force state=IDLE, reg=0, cnt=0 and lock_err=0, so that out_reg=0, clk_maj=0, busy=0, ready=0 and state_q=0.
REQ-028 reset SHALL override every other input, including mid-LOAD and par_load.

Configuration
REQ-029 Macro A51_LFSR_PARLOAD_EN defined: ports par_load (input, 1 bit) and par_data (input, WIDTH bits) SHALL exist.
REQ-030 With the macro defined: par_load=1 in any state -> reg<=par_data, cnt<=0, enter RUN; priority order is reset > par_load > start > trigger.
REQ-031 Macro A51_LFSR_PARLOAD_EN undefined: both ports SHALL be absent, and the behaviour SHALL be identical to REQ-016..REQ-028.

Verification
REQ-032 Reset, then idle 5 cycles -> all outputs 0, state IDLE.
REQ-033 Defaults; start, then 86 bits of shift_bit=1 -> busy high for exactly 86 cycles, ready rises the next cycle, and state_q matches the software model.
REQ-034 RUN with reg=23'h000001; trigger=1 for 1 cycle -> state_q=23'h000002; trigger=0 -> state_q holds.
REQ-035 start asserted at cycle 40 of LOAD -> reg cleared, cnt restarted, and RUN is reached 86 cycles later.
REQ-036 LOAD_LEN=1, shift_bit=0 after start -> RUN with state_q=0, and lock_err=1 one cycle later.
REQ-037 A51_LFSR_PARLOAD_EN defined; par_load=1, par_data=23'h7FFFFF with start=1 -> ready next cycle, state_q=23'h7FFFFF; then trigger -> state_q=23'h7FFFFE.
